// File: rtl/fft_result_reader.sv
// Streams the 1024 FFT bins out of the fft0/fft1 BSRAM banks once fft1024 has finished.
// Reads are credit-limited against the output FIFO, so every captured word always has a slot.
module fft_result_reader #(
    parameter int BIT_REVERSE = 0,
    parameter int FIFO_DEPTH  = 4,
    parameter int RD_LAT      = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        sel_o,
    input  logic [31:0] dout0_i,
    output logic        oce0_o,
    output logic        ce0_o,
    output logic        wre0_o,
    output logic [10:0] ad0_o,
    output logic [31:0] din0_o,
    input  logic [31:0] dout1_i,
    output logic        oce1_o,
    output logic        ce1_o,
    output logic        wre1_o,
    output logic [10:0] ad1_o,
    output logic [31:0] din1_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [15:0] m_re_o,
    output logic [15:0] m_im_o,
    output logic [9:0]  m_idx_o,
    output logic        m_last_o
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = 8;
    localparam int EW   = 43;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    function automatic logic [9:0] rev10(input logic [9:0] x);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = x[9 - i];
        return r;
    endfunction

    state_t                   state_q, state_d;
    logic [10:0]              cnt_q, cnt_d;
    logic                     ce0_q, ce0_d, ce1_q, ce1_d;
    logic [10:0]              ad_q, ad_d;
    logic [RD_LAT-1:0]        vld_pipe_q;
    logic [RD_LAT-1:0][10:0]  tag_pipe_q;   // {last, bin}
    logic [EW-1:0]            fifo_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]          fifo_cnt_q;

    logic [9:0]               bin;
    logic [CW-1:0]            in_flight;
    logic [CW-1:0]            credit_used;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic [10:0]              cap_tag;
    logic [EW-1:0]            rd_entry;

    always_comb begin
        bin       = (BIT_REVERSE != 0) ? rev10(cnt_q[9:0]) : cnt_q[9:0];
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(vld_pipe_q[i]);
        // Reads still in the BSRAM pipe already own a FIFO slot.
        credit_used = in_flight + CW'(fifo_cnt_q);
        issue       = (state_q == S_READ) && !cnt_q[10] && (credit_used < CW'(FIFO_DEPTH));
    end

    assign push    = vld_pipe_q[RD_LAT-1];
    assign cap_tag = tag_pipe_q[RD_LAT-1];
    assign pop     = m_valid_o && m_ready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ce0_d   = 1'b0;
        ce1_d   = 1'b0;
        ad_d    = ad_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        sel_o   = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                busy_o = 1'b1;
                sel_o  = 1'b0;
                if (issue) begin
                    cnt_d = cnt_q + 11'd1;
                    ce0_d = !bin[9];
                    ce1_d = bin[9];
                    ad_d  = {2'b00, bin[8:0]};
                    if (cnt_q == 11'd1023) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                sel_o  = 1'b0;
                if (fifo_cnt_q == '0 && vld_pipe_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ce0_q      <= 1'b0;
            ce1_q      <= 1'b0;
            ad_q       <= '0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ce0_q         <= ce0_d;
            ce1_q         <= ce1_d;
            ad_q          <= ad_d;
            vld_pipe_q[0] <= issue;
            tag_pipe_q[0] <= {cnt_q == 11'd1023, bin};
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            fifo_cnt_q <= fifo_cnt_q + CNTW'(push) - CNTW'(pop);
        end
    end

    // Entry layout: {last, idx[9:0], re[15:0], im[15:0]}; storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= {cap_tag, cap_tag[9] ? dout1_i : dout0_i};
    end

    assign rd_entry  = fifo_q[rd_ptr_q];
    assign m_valid_o = (fifo_cnt_q != '0);
    assign m_last_o  = m_valid_o & rd_entry[42];
    assign m_idx_o   = m_valid_o ? rd_entry[41:32] : 10'd0;
    assign m_re_o    = m_valid_o ? rd_entry[31:16] : 16'd0;
    assign m_im_o    = m_valid_o ? rd_entry[15:0]  : 16'd0;

    assign ce0_o  = ce0_q;
    assign ce1_o  = ce1_q;
    assign ad0_o  = ad_q;
    assign ad1_o  = ad_q;
    assign oce0_o = 1'b1;
    assign oce1_o = 1'b1;
    assign wre0_o = 1'b0;
    assign wre1_o = 1'b0;
    assign din0_o = '0;
    assign din1_o = '0;

endmodule
